// File: rtl/lcd_frame_capture.sv
// Captures a CAP_WIDTH x CAP_HEIGHT window of a DE/VS video stream as RGB565 and
// packs 16 pixels per 256-bit word (slot 0 in the MSBs) into single-cycle DDR write strobes.
module lcd_frame_capture #(
    parameter int CAP_WIDTH  = 1024,
    parameter int CAP_HEIGHT = 768,
    parameter bit VS_POL     = 1'b1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         vin_vs,
    input  logic         vin_de,
    input  logic [7:0]   vin_r,
    input  logic [7:0]   vin_g,
    input  logic [7:0]   vin_b,
    input  logic         ddr_init_done,
    input  logic         ddr_wr_full,
    output logic [255:0] ddr_data,
    output logic         ddr_wren,
    output logic         frame_start,
    output logic         frame_done,
    output logic [15:0]  drop_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [11:0] WIDTH_L  = 12'(CAP_WIDTH);
    localparam logic [11:0] HEIGHT_L = 12'(CAP_HEIGHT);

    state_t         state_q, state_d;
    logic           vs_prev_q, vs_prev_d;
    logic           de_prev_q, de_prev_d;
    logic [11:0]    px_cnt_q, px_cnt_d;
    logic [11:0]    line_cnt_q, line_cnt_d;
    logic [3:0]     slot_q, slot_d;
    logic [255:0]   pack_q, pack_d;
    logic [255:0]   ddr_data_q, ddr_data_d;
    logic           ddr_wren_q, ddr_wren_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_done_q, frame_done_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           busy_q, busy_d;

    logic           vs_act;
    logic           vs_edge;
    logic           de_fall;
    logic [15:0]    pix16;
    logic [255:0]   word_in;
    logic           start_frame;
    logic           emit;
    logic [255:0]   emit_data;

    always_comb begin
        vs_act  = (vin_vs == VS_POL);
        vs_edge = vs_act & ~vs_prev_q;
        de_fall = ~vin_de & de_prev_q;
        pix16   = {vin_b[7:3], vin_g[7:2], vin_r[7:3]};

        // Packing register with the incoming pixel dropped into the current slot.
        word_in = pack_q;
        for (int s = 0; s < 16; s++) begin
            if (slot_q == 4'(s)) begin
                word_in[255-16*s -: 16] = pix16;
            end
        end

        state_d       = state_q;
        vs_prev_d     = vs_act;
        de_prev_d     = vin_de;
        px_cnt_d      = px_cnt_q;
        line_cnt_d    = line_cnt_q;
        slot_d        = slot_q;
        pack_d        = pack_q;
        ddr_data_d    = ddr_data_q;
        ddr_wren_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        drop_cnt_d    = drop_cnt_q;
        start_frame   = 1'b0;
        emit          = 1'b0;
        emit_data     = '0;

        case (state_q)
            ST_IDLE: begin
                if (ddr_init_done) begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (vs_edge) begin
                    start_frame = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A VS edge mid-frame wins over any pixel or DE fall: the partial word is abandoned.
                if (vs_edge) begin
                    start_frame = 1'b1;
                end else if (vin_de && (px_cnt_q < WIDTH_L)) begin
                    px_cnt_d = px_cnt_q + 12'd1;
                    if (slot_q == 4'd15) begin
                        emit      = 1'b1;
                        emit_data = word_in;
                        pack_d    = '0;
                        slot_d    = 4'd0;
                    end else begin
                        pack_d = word_in;
                        slot_d = slot_q + 4'd1;
                    end
                end else if (de_fall) begin
                    if (slot_q != 4'd0) begin
                        emit      = 1'b1;
                        emit_data = pack_q;
                    end
                    slot_d   = 4'd0;
                    px_cnt_d = 12'd0;
                    pack_d   = '0;
                    if (px_cnt_q != 12'd0) begin
                        line_cnt_d = line_cnt_q + 12'd1;
                        if ((line_cnt_q + 12'd1) == HEIGHT_L) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_WAIT_VS;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d       = ST_CAPTURE;
            frame_start_d = 1'b1;
            line_cnt_d    = 12'd0;
            px_cnt_d      = 12'd0;
            slot_d        = 4'd0;
            pack_d        = '0;
            drop_cnt_d    = 16'd0;
        end

        // Losing the DDR side overrides everything; the partial word is discarded.
        if (!ddr_init_done) begin
            state_d       = ST_IDLE;
            emit          = 1'b0;
            frame_start_d = 1'b0;
            frame_done_d  = 1'b0;
            px_cnt_d      = 12'd0;
            slot_d        = 4'd0;
            pack_d        = '0;
        end

        if (emit) begin
            if (ddr_wr_full) begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else begin
                ddr_data_d = emit_data;
                ddr_wren_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            px_cnt_q      <= 12'd0;
            line_cnt_q    <= 12'd0;
            slot_q        <= 4'd0;
            pack_q        <= '0;
            ddr_data_q    <= '0;
            ddr_wren_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            drop_cnt_q    <= 16'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_prev_q     <= vs_prev_d;
            de_prev_q     <= de_prev_d;
            px_cnt_q      <= px_cnt_d;
            line_cnt_q    <= line_cnt_d;
            slot_q        <= slot_d;
            pack_q        <= pack_d;
            ddr_data_q    <= ddr_data_d;
            ddr_wren_q    <= ddr_wren_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            drop_cnt_q    <= drop_cnt_d;
            busy_q        <= busy_d;
        end
    end

    assign ddr_data    = ddr_data_q;
    assign ddr_wren    = ddr_wren_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign drop_cnt    = drop_cnt_q;
    assign busy        = busy_q;

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
- Video-in to DDR frame writer; the write-side counterpart of the 1080p LCD display reader.
- Samples a DE/VS pixel stream and converts each pixel to RGB565.
- Packs 16 pixels per 256-bit word, in exactly the layout the display reader unpacks.
- Issues single-cycle write strobes into the DDR write FIFO. Captures a CAP_WIDTH x CAP_HEIGHT window per frame.

Parameters:
- CAP_WIDTH, 1024, pixels captured per line; must be a multiple of 16, max 4095.
- CAP_HEIGHT, 768, lines captured per frame; max 4095.
- VS_POL, 1, active level of vin_vs; 1 = active-high.

Ports:
- clk  in  1  pixel clock
- nrst  in  1  asynchronous active-low reset
- vin_vs  in  1  vertical sync
- vin_de  in  1  data enable; pixel valid when high
- vin_r  in  8  red
- vin_g  in  8  green
- vin_b  in  8  blue
- ddr_init_done  in  1  DDR ready; no capture while low
- ddr_wr_full  in  1  DDR write FIFO full
- ddr_data  out  256  packed write word
- ddr_wren  out  1  one-cycle write strobe
- frame_start  out  1  one-cycle pulse when a capture frame begins
- frame_done  out  1  one-cycle pulse when CAP_HEIGHT lines are captured
- drop_cnt  out  16  words dropped due to full in the current frame; saturating
- busy  out  1  high in CAPTURE state

Behaviour:
- Reset: all outputs 0, state IDLE, all counters, packing register and edge-detect registers 0.
- Pixel format: pix16 = {B[7:3], G[7:2], R[7:3]}.
  - Pixel in slot s (0..15, s = first-to-last within the word) occupies ddr_data[255-16s -: 16].
  - Slot 0 is the MSBs.
- vs_act = (vin_vs == VS_POL). VS edge = vs_act high this cycle, low the previous cycle (registered).
- DE fall = vin_de low this cycle, high the previous cycle.
- States:
  - IDLE: wait for ddr_init_done = 1, then go to WAIT_VS.
  - WAIT_VS: on VS edge, go to CAPTURE. Same edge: pulse frame_start, clear line_cnt, px_cnt, slot, drop_cnt and the packing register.
  - CAPTURE:
    - On each clk with vin_de = 1 and px_cnt < CAP_WIDTH: write pix16 into slot, increment px_cnt and slot.
    - When slot == 15: on the same edge, ddr_data <= completed word, ddr_wren <= 1, packing register <= 0, slot <= 0.
    - Pixels with px_cnt >= CAP_WIDTH are ignored.
  - DE fall in CAPTURE:
    - If slot != 0 (short line), flush: ddr_data <= packing register with unfilled slots 0, ddr_wren <= 1.
    - Then clear slot and px_cnt.
    - If px_cnt was > 0, increment line_cnt.
    - If the new line_cnt == CAP_HEIGHT, pulse frame_done and go to WAIT_VS.
  - A full word and a flush cannot coincide, because slot is 0 after a full word.
- Latency: ddr_wren rises on the clk edge that samples the 16th pixel. It stays high exactly 1 cycle; back-to-back words are 16 cycles apart.
- Backpressure: ddr_wr_full is sampled on the edge that would assert ddr_wren.
  - If it is 1: ddr_wren stays 0, the word is discarded, drop_cnt increments (saturates at 16'hFFFF).
  - Packing continues with no stall.
- ddr_data holds its last value when ddr_wren = 0.
- VS edge during CAPTURE (short frame): abort the current partial word with no flush. Restart the frame as in WAIT_VS and pulse frame_start.
- ddr_init_done falling in any state: go to IDLE next cycle, drop the partial word, busy = 0. No ddr_wren while in IDLE/WAIT_VS.
- Reset mid-operation: immediate return to the reset state; the partial word is lost.
- Widths: px_cnt and line_cnt are 12-bit; slot is 4-bit and wraps 15 -> 0.

Test Plan:
- Reset, then ddr_init_done = 0 with DE/VS toggling -> ddr_wren never asserts; all outputs 0; busy 0.
- Init done, VS edge, one line of 16 pixels all R=F8 G=00 B=00 -> frame_start pulse. One ddr_wren on the 16th pixel edge with ddr_data = {16{16'h001F}}.
- Line of 20 pixels; pixel 0 = FFFFFF, pixel 16 = 0000F8 (B=F8), others 0 -> first word:
  - [255:240] = FFFF, rest 0.
  - At DE fall, second word: [255:240] = F800, rest 0.
  - line_cnt = 1.
- Full frame 1024x768 with 1100-pixel lines and 800 lines, no full -> exactly 49152 ddr_wren pulses and frame_done after line 768. Lines 769+ produce no writes.
- ddr_wr_full = 1 during the 3rd word of a line -> that strobe is suppressed. drop_cnt = 1; the following words are correct and unshifted.
- VS edge after 8 pixels of a line -> no flush write; frame_start pulses; the next 16 pixels form a fresh word starting at slot 0.
